matrix_input_parser: RTL and testbench

//  Input stage of the matrix storage path; the producer of the matrices that the display stage reads.

---
 rtl/matrix_input_parser.sv | 135 +++++++++++++
 tb/tb_matrix_input_parser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses ASCII "m n e0 .. e(m*n-1)" from the UART, allocates a slot,
// writes the elements row-major into BRAM and commits the slot.
module matrix_input_parser #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int MAX_DIM       = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_active,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     alloc_req,
    output logic [3:0]               alloc_m,
    output logic [3:0]               alloc_n,
    input  logic                     alloc_grant,
    input  logic                     alloc_fail,
    input  logic [ADDR_WIDTH-1:0]    alloc_addr,
    output logic                     commit,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
    output logic                     done,
    output logic [3:0]               error_code,
    output logic [3:0]               sub_state
);
    localparam int AW = ELEMENT_WIDTH + 4;
    localparam logic [AW-1:0] MAX_VAL = AW'((1 << ELEMENT_WIDTH) - 1);
    localparam logic [AW-1:0] MAX_D = AW'(MAX_DIM);

    typedef enum logic [3:0] {
        IDLE = 4'd0, GET_M, GET_N, ALLOC, GET_ELEM, COMMIT, DONE, ERROR
    } state_t;

    state_t                state, state_next;
    logic [AW-1:0]         acc, acc_dig;
    logic                  have_digit, err_entry;
    logic [ADDR_WIDTH-1:0] base;
    logic [7:0]            idx, mn;
    logic [3:0]            err_next;
    logic                  is_digit, is_delim, full, in_tok, byte_in;
    logic                  dig, tok_end, bad_char, ovf, dim_ok;

    assign mn       = {4'd0, alloc_m} * {4'd0, alloc_n};
    assign full     = idx == mn;
    assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_delim = rx_data == 8'h20 || rx_data == 8'h0D || rx_data == 8'h0A;
    // once the last element is counted, further bytes are not tokenized
    assign in_tok   = state == GET_M || state == GET_N || (state == GET_ELEM && !full);
    assign byte_in  = in_tok && rx_valid;
    assign dig      = byte_in && is_digit;
    assign tok_end  = byte_in && is_delim && have_digit;
    assign bad_char = byte_in && !is_digit && !is_delim;
    assign acc_dig  = acc * AW'(10) + AW'(rx_data[3:0]);
    assign ovf      = dig && acc_dig > MAX_VAL;
    assign dim_ok   = acc >= AW'(1) && acc <= MAX_D;

    assign alloc_req = state == ALLOC;
    assign commit    = state == COMMIT;
    assign done      = state == DONE || (state == ERROR && err_entry);
    assign sub_state = state;

    always_comb begin
        state_next = state;
        err_next   = error_code;
        if (bad_char) begin
            state_next = ERROR;
            err_next   = 4'd3;
        end else if (ovf) begin
            state_next = ERROR;
            err_next   = 4'd2;
        end else if (tok_end && state != GET_ELEM && !dim_ok) begin
            state_next = ERROR;
            err_next   = 4'd1;
        end else if (tok_end) begin
            err_next   = 4'd0;
            state_next = state == GET_M ? GET_N : state == GET_N ? ALLOC : GET_ELEM;
        end
        case (state)
            IDLE:     if (mode_active) begin
                          state_next = GET_M;
                          err_next   = 4'd0;
                      end
            ALLOC:    if (alloc_grant) state_next = GET_ELEM;
                      else if (alloc_fail) begin
                          state_next = ERROR;
                          err_next   = 4'd4;
                      end
            GET_ELEM: if (full) state_next = COMMIT;
            COMMIT:   state_next = DONE;
            DONE:     state_next = GET_M;
            ERROR:    if (rx_valid && rx_data == 8'h0A) state_next = GET_M;
            default:  ;
        endcase
        if (!mode_active) begin
            state_next = IDLE;
            err_next   = error_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            error_code  <= '0;
            err_entry   <= 1'b0;
            acc         <= '0;
            have_digit  <= 1'b0;
            alloc_m     <= '0;
            alloc_n     <= '0;
            base        <= '0;
            idx         <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            state      <= state_next;
            error_code <= err_next;
            err_entry  <= state_next == ERROR && state != ERROR;
            acc        <= (!in_tok || tok_end) ? '0 : dig ? acc_dig : acc;
            have_digit <= in_tok && !tok_end && (have_digit || dig);
            if (state == GET_M && tok_end && dim_ok) alloc_m <= acc[3:0];
            if (state == GET_N && tok_end && dim_ok) alloc_n <= acc[3:0];
            if (state == ALLOC && alloc_grant) begin
                base <= alloc_addr;
                idx  <= '0;
            end
            mem_wr_en <= mode_active && state == GET_ELEM && tok_end;
            if (state == GET_ELEM && tok_end) begin
                idx         <= idx + 8'd1;
                mem_wr_addr <= base + ADDR_WIDTH'(idx);
                mem_wr_data <= acc[ELEMENT_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_matrix_input_parser.sv
// tb_matrix_input_parser: directed strings checked against a token-level model of the parser.
module tb_matrix_input_parser;
    logic       clk = 0, rst_n = 0, mode_active = 0;
    logic [7:0] rx_data = 0;
    logic       rx_valid = 0;
    logic       alloc_req, alloc_grant = 0, alloc_fail = 0;
    logic [3:0] alloc_m, alloc_n, error_code, sub_state;
    logic [9:0] alloc_addr = 0, mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       commit, mem_wr_en, done;

    int compared = 0, mismatched = 0;
    int commits_seen = 0, model_commits = 0, model_err = 0, aw = 0;
    bit fail_policy = 0, req_d = 0;
    int exp_wa[$], exp_wd[$], exp_done[$], exp_mn[$], log_a[$], log_d[$];

    matrix_input_parser dut (
        .clk(clk), .rst_n(rst_n), .mode_active(mode_active), .rx_data(rx_data), .rx_valid(rx_valid),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n), .alloc_grant(alloc_grant),
        .alloc_fail(alloc_fail), .alloc_addr(alloc_addr), .commit(commit), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .done(done), .error_code(error_code),
        .sub_state(sub_state)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Token-level reading of the input text: what writes, allocations and done codes it must cause.
    function automatic void model(string s, bit f, int base);
        int  phase = 0, acc = -1, m = 0, n = 0, idx = 0, v;
        bit  err = 0;
        byte c;
        model_commits = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (err) begin
                if (c == 8'h0A) begin err = 0; phase = 0; end
                continue;
            end
            if (c >= 8'h30 && c <= 8'h39) begin
                acc = (acc < 0 ? 0 : acc) * 10 + (int'(c) - 48);
                if (acc > 255) begin exp_done.push_back(2); model_err = 2; err = 1; acc = -1; end
            end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
                if (acc >= 0) begin
                    v = acc;
                    acc = -1;
                    if (phase < 2 && (v < 1 || v > 5)) begin
                        exp_done.push_back(1); model_err = 1; err = 1;
                    end else begin
                        model_err = 0;
                        if (phase == 0) begin m = v; phase = 1; end
                        else if (phase == 1) begin
                            n = v;
                            exp_mn.push_back(m * 16 + n);
                            if (f) begin exp_done.push_back(4); model_err = 4; err = 1; end
                            else begin phase = 2; idx = 0; end
                        end else begin
                            exp_wa.push_back((base + idx) & 'h3FF);
                            exp_wd.push_back(v);
                            idx++;
                            if (idx == m * n) begin model_commits++; exp_done.push_back(0); phase = 0; end
                        end
                    end
                end
            end else begin
                exp_done.push_back(3); model_err = 3; err = 1; acc = -1;
            end
        end
    endfunction

    // compare process: every write, done and new allocation request against the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) begin
                log_a.push_back(int'(mem_wr_addr));
                log_d.push_back(int'(mem_wr_data));
                check("write expected", exp_wa.size() > 0, 1);
                if (exp_wa.size() > 0) begin
                    check("wr_addr", mem_wr_addr, exp_wa.pop_front());
                    check("wr_data", mem_wr_data, exp_wd.pop_front());
                end
            end
            if (commit) commits_seen++;
            if (done) begin
                check("done expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) check("done error_code", error_code, exp_done.pop_front());
            end
            if (alloc_req && !req_d) begin
                check("alloc expected", exp_mn.size() > 0, 1);
                if (exp_mn.size() > 0) check("alloc_m/n", {alloc_m, alloc_n}, exp_mn.pop_front());
            end
            req_d = alloc_req;
        end
    end

    // slot manager: answers a request on its third cycle
    initial forever begin
        @(negedge clk);
        alloc_grant = 0;
        alloc_fail = 0;
        if (alloc_req) begin
            aw++;
            if (aw == 3) begin
                if (fail_policy) alloc_fail = 1; else alloc_grant = 1;
                aw = 0;
                @(negedge clk);
                alloc_grant = 0;
                alloc_fail = 0;
                check("alloc_req released", alloc_req, 0);
            end
        end else aw = 0;
    end

    task automatic send(string s);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            w = 0;
            while (alloc_req && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) check("alloc wait timeout", w, 0);
            rx_data = s[i];
            rx_valid = 1;
            @(negedge clk);
            rx_valid = 0;
        end
    endtask

    task automatic run(string s, bit f, int base, int idle);
        int c0;
        c0 = commits_seen;
        fail_policy = f;
        alloc_addr = 10'(base);
        model(s, f, base);
        send(s);
        repeat (idle) @(negedge clk);
        check("writes drained", exp_wa.size(), 0);
        check("dones drained", exp_done.size(), 0);
        check("allocs drained", exp_mn.size(), 0);
        check("commits", commits_seen - c0, model_commits);
        check("error_code held", error_code, model_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        string s;
        int n0;
        repeat (2) @(negedge clk);
        check("rst sub_state", sub_state, 0);
        check("rst alloc_req", alloc_req, 0);
        check("rst commit", commit, 0);
        check("rst done", done, 0);
        check("rst mem_wr_en", mem_wr_en, 0);
        check("rst mem_wr_addr", mem_wr_addr, 0);
        check("rst error_code", error_code, 0);
        check("rst alloc_m", alloc_m, 0);
        rst_n = 1;
        @(negedge clk);
        check("idle sub_state", sub_state, 0);
        mode_active = 1;
        @(negedge clk);
        check("enter GET_M", sub_state, 1);

        log_a.delete();
        log_d.delete();
        run("2 2 1 20 255 0\n", 0, 'h10, 8);
        check("t1 writes", log_a.size(), 4);
        if (log_a.size() == 4) begin
            check("t1 a0", log_a[0], 'h10); check("t1 d0", log_d[0], 1);
            check("t1 a1", log_a[1], 'h11); check("t1 d1", log_d[1], 20);
            check("t1 a2", log_a[2], 'h12); check("t1 d2", log_d[2], 255);
            check("t1 a3", log_a[3], 'h13); check("t1 d3", log_d[3], 0);
        end
        check("t1 back in GET_M", sub_state, 1);

        run("6 1 9\n", 0, 'h40, 6);
        check("t2 bad dim code", error_code, 1);
        run("1 1 7\n", 0, 'h40, 8);
        check("t2 write addr", log_a[$], 'h40);
        check("t2 write data", log_d[$], 7);
        check("t2 code cleared", error_code, 0);

        n0 = log_a.size();
        run("1 2 256 \n", 0, 'h60, 6);
        check("t3 overflow code", error_code, 2);
        check("t3 no writes", log_a.size(), n0);

        run("2 a x 9\n", 0, 'h60, 6);
        check("t4 illegal code", error_code, 3);
        check("t4 back in GET_M", sub_state, 1);

        n0 = commits_seen;
        run("3 3 \n", 1, 'h60, 6);
        check("t5 alloc fail code", error_code, 4);
        check("t5 no writes", log_a.size(), n0 >= 0 ? log_a.size() : 0);
        check("t5 no commit", commits_seen, n0);

        run("  1\r\n 3   004 5 255\n", 0, 'h3FE, 8);
        check("t7 wrap addr", log_a[$], 0);
        check("t7 wrap data", log_d[$], 255);

        s = "5 5";
        for (int i = 0; i < 25; i++) s = {s, $sformatf(" %0d", i * 10)};
        s = {s, "\n"};
        run(s, 0, 'h100, 8);
        check("t8 last addr", log_a[$], 'h118);
        check("t8 last data", log_d[$], 240);

        n0 = commits_seen;
        run("2 2 1 2 ", 0, 'h30, 3);
        check("t6 partial data", log_d[$], 2);
        mode_active = 0;
        @(negedge clk);
        check("t6 IDLE", sub_state, 0);
        check("t6 alloc_req", alloc_req, 0);
        check("t6 mem_wr_en", mem_wr_en, 0);
        mode_active = 1;
        @(negedge clk);
        check("t6 GET_M", sub_state, 1);
        model_err = 0;
        check("t6 no commit", commits_seen, n0);
        run("1 1 9\n", 0, 'h50, 8);
        check("t6 fresh addr", log_a[$], 'h50);
        check("t6 fresh data", log_d[$], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
